// File: rtl/music_sequencer.sv
// Music sequencer: a free-running sample prescaler drives a sample -> tick -> row
// hierarchy that walks a song position through IDLE / PLAYING / PAUSED states,
// with optional looping between latched row bounds.
module music_sequencer #(
  parameter int SONG_LENGTH      = 512,
  parameter int SAMPLE_DIV       = 512,
  parameter int SAMPLES_PER_TICK = 882,
  parameter int TICKS_PER_ROW    = 5,
  localparam int POS_W           = $clog2(SONG_LENGTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             play_req,
  input  logic             pause_req,
  input  logic             stop_req,
  input  logic             loop_en,
  input  logic [POS_W-1:0] loop_start,
  input  logic [POS_W-1:0] loop_end,
  output logic             sample_clk,
  output logic             tick_clk,
  output logic             song_clk,
  output logic [POS_W-1:0] song_position,
  output logic             playing,
  output logic             paused,
  output logic             song_done
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int SPT_W = (SAMPLES_PER_TICK > 1) ? $clog2(SAMPLES_PER_TICK) : 1;
  localparam int TPR_W = (TICKS_PER_ROW > 1) ? $clog2(TICKS_PER_ROW) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [SPT_W-1:0] SPT_LAST = SPT_W'(SAMPLES_PER_TICK - 1);
  localparam logic [TPR_W-1:0] TPR_LAST = TPR_W'(TICKS_PER_ROW - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(SONG_LENGTH - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPlaying = 2'd1,
    StPaused  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic             sample_q, sample_d;
  logic [SPT_W-1:0] sampleCnt_q, sampleCnt_d;
  logic [TPR_W-1:0] tickCnt_q, tickCnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] startLat_q, startLat_d;
  logic [POS_W-1:0] endLat_q, endLat_d;
  logic             done_q, done_d;

  logic             playAcc;
  logic             pauseAcc;
  logic             advance;
  logic             tickHit;
  logic             rowHit;
  logic             rowEnd;
  logic             songEnd;
  logic             boundsBad;
  logic [POS_W-1:0] endRow;
  logic [POS_W-1:0] startSel;
  logic [POS_W-1:0] endSel;

  // Decode prioritised requests and the tick/row strobes; pause or stop in the
  // current cycle freezes the counters so no strobe escapes on that cycle.
  always_comb begin
    playAcc   = play_req && !stop_req;
    pauseAcc  = pause_req && !play_req && !stop_req;
    advance   = (state_q == StPlaying) && !stop_req && !pauseAcc;
    tickHit   = advance && sample_q && (sampleCnt_q == SPT_LAST);
    rowHit    = tickHit && (tickCnt_q == TPR_LAST);
    endRow    = loop_en ? endLat_q : POS_LAST;
    rowEnd    = (pos_q == endRow);
    songEnd   = rowHit && rowEnd && !loop_en;
    boundsBad = (loop_start > loop_end) || (32'(loop_end) >= SONG_LENGTH);
    startSel  = boundsBad ? '0 : loop_start;
    endSel    = boundsBad ? POS_LAST : loop_end;
  end

  // Next playback state; stop overrides everything else.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (playAcc) state_d = StPlaying;
      end
      StPlaying: begin
        if (pauseAcc)     state_d = StPaused;
        else if (songEnd) state_d = StIdle;
      end
      StPaused: begin
        if (playAcc) state_d = StPlaying;
      end
      default: state_d = StIdle;
    endcase
    if (stop_req) state_d = StIdle;
  end

  // Playback state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Free-running prescaler; the strobe is registered so the first one lands on
  // the SAMPLE_DIV-th edge after reset release.
  always_comb begin
    sample_d = (divCnt_q == DIV_LAST);
    divCnt_d = sample_d ? '0 : divCnt_q + DIV_W'(1);
  end

  // Sample/tick counters, row position and bound latching.
  always_comb begin
    sampleCnt_d = sampleCnt_q;
    tickCnt_d   = tickCnt_q;
    pos_d       = pos_q;
    startLat_d  = startLat_q;
    endLat_d    = endLat_q;
    done_d      = 1'b0;
    if (stop_req) begin
      sampleCnt_d = '0;
      tickCnt_d   = '0;
      pos_d       = '0;
    end else if ((state_q == StIdle) && playAcc) begin
      startLat_d  = startSel;
      endLat_d    = endSel;
      sampleCnt_d = '0;
      tickCnt_d   = '0;
      pos_d       = loop_en ? startSel : '0;
    end else if (advance && sample_q) begin
      sampleCnt_d = (sampleCnt_q == SPT_LAST) ? '0 : sampleCnt_q + SPT_W'(1);
      if (tickHit) begin
        tickCnt_d = rowHit ? '0 : tickCnt_q + TPR_W'(1);
        if (rowHit) begin
          if (!rowEnd) begin
            pos_d = pos_q + POS_W'(1);
          end else if (loop_en) begin
            pos_d = startLat_q;
          end else begin
            pos_d  = '0;
            done_d = 1'b1;
          end
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      divCnt_q    <= '0;
      sample_q    <= 1'b0;
      sampleCnt_q <= '0;
      tickCnt_q   <= '0;
      pos_q       <= '0;
      startLat_q  <= '0;
      endLat_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      divCnt_q    <= divCnt_d;
      sample_q    <= sample_d;
      sampleCnt_q <= sampleCnt_d;
      tickCnt_q   <= tickCnt_d;
      pos_q       <= pos_d;
      startLat_q  <= startLat_d;
      endLat_q    <= endLat_d;
      done_q      <= done_d;
    end
  end

  assign sample_clk    = sample_q;
  assign tick_clk      = tickHit;
  assign song_clk      = rowHit;
  assign song_position = pos_q;
  assign playing       = (state_q == StPlaying);
  assign paused        = (state_q == StPaused);
  assign song_done     = done_q;

endmodule

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 Parameter SONG_LENGTH, default 512: number of song rows; POS_W = $clog2(SONG_LENGTH).
REQ-002 Parameter SAMPLE_DIV, default 512: clk cycles per sample_clk strobe (>=2).
REQ-003 Parameter SAMPLES_PER_TICK, default 882: sample strobes per tick (>=1).
REQ-004 Parameter TICKS_PER_ROW, default 5: ticks per song row (>=1).
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 play_req  in  1  one-cycle request: start from IDLE, resume from PAUSED.
REQ-008 pause_req  in  1  one-cycle request: freeze playback.
REQ-009 stop_req  in  1  one-cycle request: abort to IDLE.
REQ-010 loop_en  in  1  level; 1 = wrap loop_end -> loop_start, 0 = end song.
REQ-011 loop_start, loop_end  in  POS_W each  loop bounds, latched on IDLE->PLAYING.
REQ-012 sample_clk  out  1  one-cycle sample strobe.
REQ-013 tick_clk  out  1  one-cycle tick strobe, always coincident with a sample_clk.
REQ-014 song_clk  out  1  one-cycle row strobe, coincident with the last tick of a row.
REQ-015 song_position  out  POS_W  current row.
REQ-016 playing, paused  out  1 each  state flags.
REQ-017 song_done  out  1  one-cycle pulse at song end (loop_en=0).

Function
REQ-018 Sample prescaler runs in all states: sample_clk high for 1 cycle every SAMPLE_DIV cycles, first high on the SAMPLE_DIV-th rising edge after rst_n goes high; never gated by state.
REQ-019 State machine IDLE, PLAYING, PAUSED; playing=1 only in PLAYING, paused=1 only in PAUSED.
REQ-020 Request priority in the same cycle: stop_req > play_req > pause_req; lower-priority requests are dropped.
REQ-021 IDLE + play_req -> PLAYING; next cycle: sample-in-tick counter=0, tick-in-row counter=0, song_position=latched loop_start if loop_en else 0.
REQ-022 Latch: if loop_start > loop_end or loop_end >= SONG_LENGTH, latched start=0 and latched end=SONG_LENGTH-1.
REQ-023 PLAYING: each sample_clk increments the sample-in-tick counter; tick_clk asserts on the sample_clk at which the counter equals SAMPLES_PER_TICK-1, and the counter wraps to 0.
REQ-024 song_clk = tick_clk AND tick-in-row counter == TICKS_PER_ROW-1; the tick counter otherwise increments per tick and clears on song_clk.
REQ-025 song_position changes only on the edge ending a song_clk cycle (1-cycle latency); it is stable at all other times.
REQ-026 Row advance: position != end -> position+1; position == end with loop_en=1 -> latched start; with loop_en=0 and end reached -> song_position=0, state IDLE, song_done=1 for the next cycle only.
REQ-027 With loop_en=0 the end row is SONG_LENGTH-1 (loop_end ignored); loop_en is sampled at each row advance.
REQ-028 PLAYING + pause_req -> PAUSED: counters and position frozen, tick_clk/song_clk held 0.
REQ-029 PAUSED + play_req -> PLAYING, counters resume from frozen values (no clear).
REQ-030 stop_req in any state -> IDLE next cycle; position and both counters cleared; song_done not asserted.
REQ-031 play_req in PLAYING, pause_req in IDLE/PAUSED: ignored.
REQ-032 tick_clk, song_clk 0 in IDLE and PAUSED, including on the cycle a request is accepted.

Reset
REQ-033 While rst_n=0 at a rising edge: state IDLE; all counters 0; song_position=0; sample_clk, tick_clk, song_clk, playing, paused, song_done = 0; reset mid-play behaves identically.

Verification (SONG_LENGTH=8, SAMPLE_DIV=4, SAMPLES_PER_TICK=3, TICKS_PER_ROW=2)
REQ-034 Reset release, no requests -> sample_clk every 4 cycles, first on 4th edge; tick_clk never high; song_position=0.
REQ-035 play_req, loop_en=0 -> tick_clk every 12 cycles, song_clk every 24; position 0..7, then song_done pulse once, playing=0, position=0.
REQ-036 loop_en=1, loop_start=2, loop_end=4 -> position 2,3,4,2,3,4,...; song_done never; start=5, end=3 -> full 0..7 loop.
REQ-037 pause_req mid-row at position 3, hold 50 cycles, play_req -> no ticks during pause; first tick after resume lands at frozen-count offset; position continues 3->4.
REQ-038 stop_req, play_req, pause_req same cycle while PLAYING -> IDLE, position 0; rst_n low mid-play -> all outputs 0 next edge.
